// File: rtl/axi_aw_w_dispatch_pkg.sv
// Shared definitions for the AW/W dispatch stage: packed FIFO entry layout,
// state encoding and AXI burst/size constants.
package axi_aw_w_dispatch_pkg;

  // Entry layout, MSB to LSB: {id, addr, len, size, burst}
  localparam int BURST_LSB    = 0;
  localparam int BURST_W      = 2;
  localparam int SIZE_LSB     = 2;
  localparam int SIZE_W       = 3;
  localparam int LEN_LSB      = 5;
  localparam int LEN_W        = 8;
  localparam int ADDR_LSB     = 13;
  localparam int INFO_FIXED_W = 13;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_AW_ISSUE = 2'd1;
  localparam logic [1:0] ST_W_XFER   = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    AW_ISSUE = ST_AW_ISSUE,
    W_XFER   = ST_W_XFER
  } state_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B  = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B  = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B  = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B  = 3'd3;

endpackage

// File: rtl/axi_aw_w_dispatch.sv
// Pops one queued write address at a time, issues it on AW, then forwards the
// matching W beats with WLAST generated from the latched burst length.
module axi_aw_w_dispatch
  import axi_aw_w_dispatch_pkg::*;
#(
  parameter int ID_WIDTH   = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AW_INFO_W  = ID_WIDTH + ADDR_WIDTH + INFO_FIXED_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW_INFO_W-1:0]    aw_fifo_data_i,
  input  logic                    aw_fifo_empty_i,
  output logic                    aw_fifo_rd_valid_o,
  output logic [ID_WIDTH-1:0]     m_awid_o,
  output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
  output logic [7:0]              m_awlen_o,
  output logic [2:0]              m_awsize_o,
  output logic [1:0]              m_awburst_o,
  output logic                    m_awvalid_o,
  input  logic                    m_awready_i,
  input  logic [DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic                    s_wvalid_i,
  output logic                    s_wready_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
  output logic                    m_wlast_o,
  output logic                    m_wvalid_o,
  input  logic                    m_wready_i,
  output logic                    busy_o
);

  localparam int ID_LSB = ADDR_LSB + ADDR_WIDTH;

  state_t                  state_reg, state_next;
  logic [7:0]              beat_cnt_reg;
  logic [ID_WIDTH-1:0]     awid_reg;
  logic [ADDR_WIDTH-1:0]   awaddr_reg;
  logic [LEN_W-1:0]        awlen_reg;
  logic [SIZE_W-1:0]       awsize_reg;
  logic [BURST_W-1:0]      awburst_reg;

  logic in_w_xfer;
  logic w_hs;
  logic w_last;
  logic pop;

  assign in_w_xfer = (state_reg == W_XFER);
  assign w_last    = in_w_xfer && (beat_cnt_reg == awlen_reg);
  assign w_hs      = in_w_xfer && s_wvalid_i && m_wready_i;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!aw_fifo_empty_i) begin
          pop        = 1'b1;
          state_next = AW_ISSUE;
        end
      end
      AW_ISSUE: begin
        if (m_awready_i) state_next = W_XFER;
      end
      W_XFER: begin
        // Last beat either chains straight into the next queued entry or idles
        if (w_hs && w_last) begin
          if (!aw_fifo_empty_i) begin
            pop        = 1'b1;
            state_next = AW_ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      awid_reg     <= '0;
      awaddr_reg   <= '0;
      awlen_reg    <= '0;
      awsize_reg   <= '0;
      awburst_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        awid_reg     <= aw_fifo_data_i[ID_LSB +: ID_WIDTH];
        awaddr_reg   <= aw_fifo_data_i[ADDR_LSB +: ADDR_WIDTH];
        awlen_reg    <= aw_fifo_data_i[LEN_LSB +: LEN_W];
        awsize_reg   <= aw_fifo_data_i[SIZE_LSB +: SIZE_W];
        awburst_reg  <= aw_fifo_data_i[BURST_LSB +: BURST_W];
        beat_cnt_reg <= '0;
      end else if (w_hs) begin
        // Cleared on the last beat so a 256-beat burst never wraps the counter
        beat_cnt_reg <= w_last ? 8'd0 : beat_cnt_reg + 8'd1;
      end
    end
  end

  assign aw_fifo_rd_valid_o = pop;
  assign m_awvalid_o        = (state_reg == AW_ISSUE);
  assign busy_o             = (state_reg != IDLE);

  assign m_awid_o    = awid_reg;
  assign m_awaddr_o  = awaddr_reg;
  assign m_awlen_o   = awlen_reg;
  assign m_awsize_o  = awsize_reg;
  assign m_awburst_o = awburst_reg;

  assign m_wvalid_o = in_w_xfer && s_wvalid_i;
  assign s_wready_o = in_w_xfer && m_wready_i;
  assign m_wlast_o  = w_last;
  assign m_wdata_o  = s_wdata_i;
  assign m_wstrb_o  = s_wstrb_i;

endmodule

// File: tb/tb_axi_aw_w_dispatch.sv
// Randomized self-checking bench for axi_aw_w_dispatch: a transaction-level
// model of the burst in flight predicts every output each cycle.
module tb_axi_aw_w_dispatch;

  localparam int ID_W   = 5;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int INFO_W = ID_W + ADDR_W + 13;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [INFO_W-1:0] aw_fifo_data = '0;
  logic              aw_fifo_empty = 1'b1;
  logic              aw_fifo_rd_valid;
  logic [ID_W-1:0]   m_awid;
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0]        m_awlen;
  logic [2:0]        m_awsize;
  logic [1:0]        m_awburst;
  logic              m_awvalid;
  logic              m_awready = 1'b0;
  logic [DATA_W-1:0] s_wdata = '0;
  logic [STRB_W-1:0] s_wstrb = '0;
  logic              s_wvalid = 1'b0;
  logic              s_wready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_wlast;
  logic              m_wvalid;
  logic              m_wready = 1'b0;
  logic              busy;

  always #5 clk = ~clk;

  axi_aw_w_dispatch #(
    .ID_WIDTH  (ID_W),
    .ADDR_WIDTH(ADDR_W),
    .DATA_WIDTH(DATA_W),
    .AW_INFO_W (INFO_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .aw_fifo_data_i    (aw_fifo_data),
    .aw_fifo_empty_i   (aw_fifo_empty),
    .aw_fifo_rd_valid_o(aw_fifo_rd_valid),
    .m_awid_o          (m_awid),
    .m_awaddr_o        (m_awaddr),
    .m_awlen_o         (m_awlen),
    .m_awsize_o        (m_awsize),
    .m_awburst_o       (m_awburst),
    .m_awvalid_o       (m_awvalid),
    .m_awready_i       (m_awready),
    .s_wdata_i         (s_wdata),
    .s_wstrb_i         (s_wstrb),
    .s_wvalid_i        (s_wvalid),
    .s_wready_o        (s_wready),
    .m_wdata_o         (m_wdata),
    .m_wstrb_o         (m_wstrb),
    .m_wlast_o         (m_wlast),
    .m_wvalid_o        (m_wvalid),
    .m_wready_i        (m_wready),
    .busy_o            (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Upstream FIFO contents, slave-side beats still to send, beats expected at master
  logic [INFO_W-1:0] fifo_q[$];
  beat_t             src_q[$];
  beat_t             sink_q[$];

  // Model of the burst in flight
  bit                have_burst = 1'b0;
  bit                aw_done    = 1'b0;
  int                beats_done = 0;
  logic [INFO_W-1:0] cur        = '0;

  int p_awready = 100;
  int p_wready  = 100;
  int p_wvalid  = 100;
  int fwd_beats = 0;
  int fwd_lasts = 0;

  bit    smp_pop, smp_w_hs, smp_last_hs, smp_aw_hs, smp_src_hs, smp_snk_hs;
  beat_t smp_snk_beat;
  logic  smp_snk_last;

  function automatic logic [ID_W-1:0] f_id(input logic [INFO_W-1:0] e);
    return e[INFO_W-1 -: ID_W];
  endfunction
  function automatic logic [ADDR_W-1:0] f_addr(input logic [INFO_W-1:0] e);
    return e[13 +: ADDR_W];
  endfunction
  function automatic logic [7:0] f_len(input logic [INFO_W-1:0] e);
    return e[12:5];
  endfunction
  function automatic logic [2:0] f_size(input logic [INFO_W-1:0] e);
    return e[4:2];
  endfunction
  function automatic logic [1:0] f_burst(input logic [INFO_W-1:0] e);
    return e[1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic queue_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [DATA_W-1:0] first_data,
                             input bit rand_data);
    beat_t b;
    fifo_q.push_back({id, addr, len, size, burst});
    for (int i = 0; i <= int'(len); i++) begin
      b.data = rand_data ? DATA_W'($urandom) : first_data + DATA_W'(i);
      b.strb = rand_data ? STRB_W'($urandom_range(1, 15)) : STRB_W'(4'hF);
      src_q.push_back(b);
      sink_q.push_back(b);
    end
    $display("queue: id=%0d addr=0x%08h len=%0d", id, addr, len);
  endtask

  task automatic drive_inputs();
    m_awready = ($urandom_range(0, 99) < p_awready);
    m_wready  = ($urandom_range(0, 99) < p_wready);
    s_wvalid  = (src_q.size() > 0) && ($urandom_range(0, 99) < p_wvalid);
    if (s_wvalid) {s_wdata, s_wstrb} = src_q[0];
    else          {s_wdata, s_wstrb} = {DATA_W'($urandom), STRB_W'($urandom)};
    aw_fifo_empty = (fifo_q.size() == 0);
    aw_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : INFO_W'({$urandom, $urandom});
  endtask

  task automatic check_and_sample();
    bit exp_last, w_hs, exp_pop;
    if (!rst_n) begin
      have_burst = 1'b0; aw_done = 1'b0; beats_done = 0; cur = '0;
    end
    exp_last = have_burst && aw_done && (beats_done == int'(f_len(cur)));
    w_hs     = have_burst && aw_done && s_wvalid && m_wready;
    exp_pop  = rst_n && (fifo_q.size() > 0) && (!have_burst || (w_hs && exp_last));
    if (rst_n) chk("pop", 64'(aw_fifo_rd_valid), 64'(exp_pop));
    chk("awvalid", 64'(m_awvalid), 64'(have_burst && !aw_done));
    chk("busy",    64'(busy),      64'(have_burst));
    chk("awid",    64'(m_awid),    64'(f_id(cur)));
    chk("awaddr",  64'(m_awaddr),  64'(f_addr(cur)));
    chk("awlen",   64'(m_awlen),   64'(f_len(cur)));
    chk("awsize",  64'(m_awsize),  64'(f_size(cur)));
    chk("awburst", 64'(m_awburst), 64'(f_burst(cur)));
    chk("wvalid",  64'(m_wvalid),  64'(have_burst && aw_done && s_wvalid));
    chk("s_wready", 64'(s_wready), 64'(have_burst && aw_done && m_wready));
    chk("wlast",   64'(m_wlast),   64'(exp_last));
    smp_pop      = exp_pop;
    smp_w_hs     = w_hs;
    smp_last_hs  = w_hs && exp_last;
    smp_aw_hs    = have_burst && !aw_done && m_awready;
    smp_src_hs   = s_wvalid && s_wready;
    smp_snk_hs   = m_wvalid && m_wready;
    smp_snk_beat = {m_wdata, m_wstrb};
    smp_snk_last = m_wlast;
  endtask

  task automatic update_model();
    beat_t exp_b;
    if (smp_src_hs) void'(src_q.pop_front());
    if (smp_snk_hs) begin
      chk("sink_has_expected_beat", 64'(sink_q.size() > 0), 64'(1));
      if (sink_q.size() > 0) begin
        exp_b = sink_q.pop_front();
        chk("wdata", 64'(smp_snk_beat.data), 64'(exp_b.data));
        chk("wstrb", 64'(smp_snk_beat.strb), 64'(exp_b.strb));
      end
      fwd_beats++;
      if (smp_snk_last) fwd_lasts++;
    end
    if (smp_w_hs && !smp_last_hs) beats_done++;
    if (smp_last_hs) have_burst = 1'b0;
    if (smp_aw_hs) aw_done = 1'b1;
    if (smp_pop) begin
      cur = fifo_q.pop_front();
      have_burst = 1'b1; aw_done = 1'b0; beats_done = 0;
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk);
    check_and_sample();
    @(posedge clk);
    if (rst_n) update_model();
    #1;
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles, output int cycles);
    cycles = 0;
    while (!(fifo_q.size() == 0 && !have_burst && src_q.size() == 0) && cycles < max_cycles) begin
      step();
      cycles++;
    end
    chk({tag, "_completes"}, 64'(cycles < max_cycles), 64'(1));
    step();
  endtask

  initial begin
    int b0, l0, n, tot;
    logic [7:0] len_r;

    // Reset held with a non-empty FIFO, then released
    queue_burst(5'd3, 32'h0000_1000, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk); #1;
    repeat (3) step();
    chk("reset_no_pop", 64'(fifo_q.size()), 64'(1));
    rst_n = 1'b1;
    b0 = fwd_beats; l0 = fwd_lasts;
    run_until_idle("single", 50, n);
    chk("single_cycles", 64'(n), 64'(3));
    chk("single_beats", 64'(fwd_beats - b0), 64'(1));
    chk("single_lasts", 64'(fwd_lasts - l0), 64'(1));
    $display("txn single: cycles=%0d beats=%0d", n, fwd_beats - b0);

    // AW backpressure with W data waiting
    b0 = fwd_beats; l0 = fwd_lasts;
    p_awready = 0;
    queue_burst(5'd5, 32'h2000_0040, 8'd2, 3'd2, 2'b01, 32'h1111_0000, 1'b0);
    repeat (12) step();
    chk("aw_stall_no_w", 64'(fwd_beats - b0), 64'(0));
    p_awready = 100;
    run_until_idle("aw_stall", 50, n);
    chk("aw_stall_beats", 64'(fwd_beats - b0), 64'(3));
    chk("aw_stall_lasts", 64'(fwd_lasts - l0), 64'(1));
    $display("txn aw_stall: beats=%0d", fwd_beats - b0);

    // 256-beat burst with random stalls on every handshake
    b0 = fwd_beats; l0 = fwd_lasts;
    p_awready = 50; p_wready = 50; p_wvalid = 80;
    queue_burst(ID_W'($urandom), ADDR_W'($urandom), 8'd255, 3'd2, 2'b01, 32'h0, 1'b1);
    run_until_idle("long", 4000, n);
    chk("long_beats", 64'(fwd_beats - b0), 64'(256));
    chk("long_lasts", 64'(fwd_lasts - l0), 64'(1));
    $display("txn long: cycles=%0d beats=%0d", n, fwd_beats - b0);

    // Back-to-back bursts: each subsequent burst costs len+2 cycles
    b0 = fwd_beats; l0 = fwd_lasts;
    p_awready = 100; p_wready = 100; p_wvalid = 100;
    queue_burst(5'd1, 32'h3000_0000, 8'd1, 3'd2, 2'b01, 32'hA000_0000, 1'b0);
    queue_burst(5'd2, 32'h3000_0100, 8'd0, 3'd1, 2'b00, 32'hB000_0000, 1'b0);
    queue_burst(5'd4, 32'h3000_0200, 8'd3, 3'd2, 2'b10, 32'hC000_0000, 1'b0);
    run_until_idle("b2b", 100, n);
    chk("b2b_cycles", 64'(n), 64'(1 + (1 + 2) + (0 + 2) + (3 + 2)));
    chk("b2b_beats", 64'(fwd_beats - b0), 64'(7));
    chk("b2b_lasts", 64'(fwd_lasts - l0), 64'(3));
    $display("txn b2b: cycles=%0d beats=%0d", n, fwd_beats - b0);

    // Reset asserted mid-burst after the second beat
    b0 = fwd_beats;
    queue_burst(5'd7, 32'h4000_0000, 8'd7, 3'd2, 2'b01, 32'hE000_0000, 1'b0);
    n = 0;
    while (fwd_beats - b0 < 2 && n < 20) begin step(); n++; end
    chk("midrst_reach_beat2", 64'(fwd_beats - b0), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_awvalid", 64'(m_awvalid), 64'(0));
    chk("midrst_busy",    64'(busy),      64'(0));
    chk("midrst_wvalid",  64'(m_wvalid),  64'(0));
    chk("midrst_s_wready", 64'(s_wready), 64'(0));
    chk("midrst_wlast",   64'(m_wlast),   64'(0));
    chk("midrst_awaddr",  64'(m_awaddr),  64'(0));
    chk("midrst_awlen",   64'(m_awlen),   64'(0));
    have_burst = 1'b0; aw_done = 1'b0; beats_done = 0; cur = '0;
    src_q.delete(); sink_q.delete();
    b0 = fwd_beats;
    repeat (3) step();
    chk("midrst_no_more_beats", 64'(fwd_beats - b0), 64'(0));
    rst_n = 1'b1;
    b0 = fwd_beats; l0 = fwd_lasts;
    p_awready = 70; p_wready = 70; p_wvalid = 70;
    queue_burst(5'd9, 32'h5000_0000, 8'd2, 3'd2, 2'b01, 32'h0, 1'b1);
    run_until_idle("after_rst", 100, n);
    chk("after_rst_beats", 64'(fwd_beats - b0), 64'(3));
    chk("after_rst_lasts", 64'(fwd_lasts - l0), 64'(1));
    $display("txn mid_reset: restart beats=%0d", fwd_beats - b0);

    // Random mix of short bursts and handshake rates
    b0 = fwd_beats; l0 = fwd_lasts; tot = 0;
    p_awready = int'($urandom_range(30, 100));
    p_wready  = int'($urandom_range(30, 100));
    p_wvalid  = int'($urandom_range(30, 100));
    for (int i = 0; i < 6; i++) begin
      len_r = 8'($urandom_range(0, 15));
      tot += int'(len_r) + 1;
      queue_burst(ID_W'($urandom), ADDR_W'($urandom), len_r, 3'($urandom), 2'($urandom), 32'h0, 1'b1);
    end
    run_until_idle("random", 2000, n);
    chk("random_beats", 64'(fwd_beats - b0), 64'(tot));
    chk("random_lasts", 64'(fwd_lasts - l0), 64'(6));
    $display("txn random: cycles=%0d beats=%0d", n, fwd_beats - b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
